if_prefetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID register and decode.
- Owns the fetch PC and issues in-order word requests to instruction memory with variable latency.
- Buffers returned instructions in a small prefetch queue and presents them to decode under a ready/valid handshake.
- Handles branch/jump redirects from EX and stops fetching at the all-zero halt word.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/if_prefetch_unit_if.sv | 15 +
 rtl/if_prefetch_unit_fifo.sv | 61 ++++++
 rtl/if_prefetch_unit.sv | 116 +++++++++++
 tb/tb_if_prefetch_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V pipeline stages.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_HALT = 32'h0000_0000;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave). Responses return in request order.
interface if_prefetch_unit_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);

    logic            req;
    logic [XLEN-1:0] addr;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);

endinterface

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous prefetch FIFO: registered storage, so there is no empty
// bypass; flush empties it in one cycle.
module if_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    // Underflow guard: decode must never pop an empty queue.
    always_ff @(posedge clk) begin
        if (rst && !flush) assert (!(pop && empty));
    end

    always_comb begin
        head  = mem[rd_ptr];
        full  = (cnt == CW'(DEPTH));
        empty = (cnt == '0);
        count = cnt;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited word
// requests, queues returned instructions and hands them to decode.
module if_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    if_prefetch_unit_if.master       imem,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     instr_valid,
    output logic [XLEN-1:0]          instr,
    output logic [XLEN-1:0]          pc,
    output logic [XLEN-1:0]          pc_plus4,
    input  logic                     decode_ready,
    output logic                     halted
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   rsp_pc;
    logic [XLEN-1:0]   target;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     count;
    logic [CW:0]       credit_sum;
    logic [CW:0]       flush_sum;
    logic [CW-1:0]     drop_flush;
    logic              issue;
    logic              enq;
    logic              deq;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;

    if_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data ({rsp_pc, imem.rdata}),
        .pop       (deq),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // Issue/credit decisions, drop reload value and decode-side outputs.
    always_comb begin
        target     = redirect_pc & ~XLEN'(3);
        credit_sum = {1'b0, count} + {1'b0, outstanding};
        // rst gates the request so nothing is issued that reset would forget.
        issue      = rst & !halted & !redirect_valid & (credit_sum < (CW+1)'(DEPTH));
        enq        = rst & !redirect_valid & imem.rvalid & (drop == '0);
        instr_valid = !fifo_empty & !redirect_valid;
        deq        = instr_valid & decode_ready;

        // Everything still in flight must be discarded after a redirect or
        // reset; a response arriving this very cycle is already consumed.
        flush_sum = {1'b0, outstanding} + {1'b0, drop};
        if (imem.rvalid && (flush_sum != '0)) flush_sum = flush_sum - 1'b1;
        drop_flush = (flush_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : flush_sum[CW-1:0];

        imem.req  = issue;
        imem.addr = fetch_pc;

        instr    = fifo_empty ? '0 : head[XLEN-1:0];
        pc       = fifo_empty ? '0 : head[2*XLEN-1:XLEN];
        pc_plus4 = fifo_empty ? '0 : head[2*XLEN-1:XLEN] + XLEN'(INSTR_BYTES);
    end

    // Fetch PC, response PC, credit/drop counters and sticky halt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= drop_flush;
            halted      <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= target;
            rsp_pc      <= target;
            outstanding <= '0;
            drop        <= drop_flush;
            halted      <= 1'b0;
        end else begin
            if (issue) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            case ({issue, enq})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (imem.rvalid && (drop != '0)) drop <= drop - 1'b1;
            if (enq) begin
                // Responses are in order, so the next kept one is rsp_pc.
                rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
                if (imem.rdata == XLEN'(NOP_HALT)) halted <= 1'b1;
            end
        end
    end

    // The credit rule must keep enqueues away from a full queue.
    always_ff @(posedge clk) begin
        if (rst) assert (!(enq && fifo_full));
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with an in-order variable-latency
// instruction memory model.
module tb_if_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        decode_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;

    if_prefetch_unit_if #(.XLEN(32)) imem_bus ();

    if_prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .decode_ready   (decode_ready),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic        stall = 1'b0;
    logic [31:0] halt_addr = 32'hFFFF_FFF0;

    logic [31:0] req_q[$];
    int          due_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_in[$];
    logic [31:0] got_p4[$];
    int          got_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == halt_addr) return 32'h0;
        return {a[19:0], 12'h013};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory and decode act mid-cycle, then the edge, then #1.
    task automatic tick();
        @(negedge clk);
        if (imem_bus.req) begin
            req_q.push_back(imem_bus.addr);
            due_q.push_back(cyc + lat);
            addr_log.push_back(imem_bus.addr);
        end
        if (!stall && due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_bus.rvalid = 1'b1;
            imem_bus.rdata  = mem_word(req_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            imem_bus.rvalid = 1'b0;
            imem_bus.rdata  = '0;
        end
        if (instr_valid && decode_ready) begin
            got_pc.push_back(pc);
            got_in.push_back(instr);
            got_p4.push_back(pc_plus4);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        got_pc.delete();
        got_in.delete();
        got_p4.delete();
        got_cyc.delete();
    endtask

    // Hold reset until every in-flight response has come back.
    task automatic do_reset();
        decode_ready   = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        rst            = 1'b0;
        tick();
        for (int i = 0; i < 50 && req_q.size() > 0; i++) tick();
        check_eq("drain", req_q.size(), 0);
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic check_got(input string tag, input int idx, input logic [31:0] exp_pc);
        if (idx < got_pc.size()) begin
            check_eq({tag, "_pc"}, got_pc[idx], exp_pc);
            check_eq({tag, "_instr"}, got_in[idx], mem_word(exp_pc));
        end else begin
            check_eq({tag, "_count"}, got_pc.size(), idx + 1);
        end
    endtask

    task automatic check_addr(input string tag, input int idx, input logic [31:0] exp);
        if (idx < addr_log.size()) check_eq(tag, addr_log[idx], exp);
        else check_eq({tag, "_count"}, addr_log.size(), idx + 1);
    endtask

    initial begin
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_req", imem_bus.req, 0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_pc4", pc_plus4, 0);
        rst = 1'b1;
        #1;
        check_eq("first_req", imem_bus.req, 1);
        check_eq("first_addr", imem_bus.addr, 32'h0);

        // Straight-line fetch, latency 1, decode always ready
        decode_ready = 1'b1;
        repeat (20) tick();
        for (int i = 0; i < 4; i++) check_addr("seq_addr", i, 32'(4 * i));
        for (int i = 0; i < 8; i++) check_got("seq", i, 32'(4 * i));
        if (got_p4.size() > 2) check_eq("seq_pc4", got_p4[2], 32'hC);
        else check_eq("seq_pc4_count", got_p4.size(), 3);
        if (got_cyc.size() > 7) check_eq("seq_no_gap", got_cyc[7] - got_cyc[0], 7);
        else check_eq("seq_gap_count", got_cyc.size(), 8);

        // Latency 3 with decode stalled: credit limit and stable head
        do_reset();
        lat = 3;
        repeat (10) begin
            tick();
            if (instr_valid) check_eq("hold_pc", pc, 32'h0);
        end
        check_eq("credit_limit", addr_log.size(), 4);
        check_eq("hold_valid", instr_valid, 1);
        check_eq("hold_instr", instr, mem_word(32'h0));
        decode_ready = 1'b1;
        repeat (20) tick();
        check_addr("resume_addr", 4, 32'h10);
        for (int i = 0; i < 6; i++) check_got("resume", i, 32'(4 * i));

        // Redirect with two queued and two in flight
        do_reset();
        lat   = 1;
        stall = 1'b1;
        repeat (6) tick();
        check_eq("pre_redir_reqs", addr_log.size(), 4);
        stall = 1'b0;
        repeat (2) tick();
        stall = 1'b1;
        check_eq("pre_redir_valid", instr_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        #1;
        check_eq("redir_req", imem_bus.req, 0);
        check_eq("redir_valid", instr_valid, 0);
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        decode_ready   = 1'b1;
        clear_logs();
        repeat (15) tick();
        check_addr("redir_addr", 0, 32'h40);
        check_got("redir", 0, 32'h40);
        check_got("redir", 1, 32'h44);

        // Redirect coincident with a response and a ready decode
        do_reset();
        lat          = 1;
        decode_ready = 1'b1;
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #1;
        check_eq("coin_valid", instr_valid, 0);
        check_eq("coin_req", imem_bus.req, 0);
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        repeat (10) tick();
        check_got("coin", 0, 32'h80);
        check_got("coin", 1, 32'h84);

        // Halt word at 0xC
        do_reset();
        halt_addr    = 32'hC;
        lat          = 1;
        decode_ready = 1'b1;
        repeat (20) tick();
        check_eq("halt_set", halted, 1);
        check_eq("halt_reqs", addr_log.size(), 5);
        check_eq("halt_delivered", got_pc.size(), 5);
        check_got("halt", 3, 32'hC);
        check_got("halt", 4, 32'h10);
        check_eq("halt_drained", instr_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("halt_cleared", halted, 0);
        check_eq("halt_restart_req", imem_bus.req, 1);
        check_eq("halt_restart_addr", imem_bus.addr, 32'h0);
        halt_addr = 32'hFFFF_FFF0;

        // One-cycle reset with three responses in flight
        do_reset();
        lat          = 5;
        decode_ready = 1'b1;
        repeat (3) tick();
        check_eq("mid_rst_reqs", addr_log.size(), 3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_logs();
        repeat (40) tick();
        for (int i = 0; i < 6; i++) check_got("mid_rst", i, 32'(4 * i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
